// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
//   clk, rst_n                        clock, async active-low reset
//   if_req/if_addr -> if_ack          fetch read request and completion pulse
//   d_req/d_we/d_addr/d_wdata -> d_ack data load/store request and completion pulse
//   rdata, err                        response data and timeout flag, valid with an ack
//   mem_req/mem_we/mem_addr/mem_wdata memory request side, held stable while BUSY
//   mem_ready/mem_rdata               memory completion and read data
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int DATA_MAX = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(DATA_MAX + 1);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);
  localparam logic [SW-1:0] S_MAX = SW'(DATA_MAX);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic own_d;
  logic [WW-1:0] wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic gnt_d;
  // data wins unless fetch has already waited through DATA_MAX data grants
  assign gnt_d = d_req && !(if_req && starve_cnt == S_MAX);
  // decoded from state only, so an async reset drops mem_req at once
  assign mem_req = state == BUSY;
  assign if_ack = state == RESP && !own_d;
  assign d_ack = state == RESP && own_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      own_d      <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (if_req || d_req) begin
          state      <= BUSY;
          own_d      <= gnt_d;
          wait_cnt   <= '0;
          mem_addr   <= gnt_d ? d_addr : if_addr;
          mem_we     <= gnt_d && d_we;
          mem_wdata  <= gnt_d ? d_wdata : '0;
          starve_cnt <= (gnt_d && if_req) ? (starve_cnt == S_MAX ? S_MAX : starve_cnt + 1'b1) : '0;
        end
        BUSY: if (mem_ready) begin
          rdata <= mem_we ? '0 : mem_rdata;
          err   <= 1'b0;
          state <= RESP;
        end else if (wait_cnt == TO_LAST) begin
          rdata <= '0;
          err   <= 1'b1;
          state <= RESP;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, waits, timeout and reset
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr;
  logic [63:0] d_wdata, mem_rdata;
  logic        if_ack, d_ack, err, mem_req, mem_we;
  logic [63:0] rdata, mem_wdata;
  logic [31:0] mem_addr;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .DATA_MAX(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic quiet(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_d_ack"}, d_ack, 0);
  endtask
  // both requesters held high, zero-wait memory; grant order D,D,D,D,I repeating
  task automatic run_both(input int n);
    if_req = 1; d_req = 1; d_we = 0; if_addr = 32'h1000; d_addr = 32'h2000;
    mem_ready = 1; mem_rdata = 64'hAAAA;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("both_busy", mem_req, 1);
      chk("both_grant_addr", mem_addr, (i % 5 != 4) ? 32'h2000 : 32'h1000);
      @(negedge clk);
      chk("both_d_ack", d_ack, (i % 5 != 4) ? 1 : 0);
      chk("both_if_ack", if_ack, (i % 5 != 4) ? 0 : 1);
      chk("both_rdata", rdata, 64'hAAAA);
      if (i == n - 1) begin if_req = 0; d_req = 0; mem_ready = 0; end
      @(negedge clk);
      quiet("both_idle");
    end
  endtask
  initial begin
    rst_n = 0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    @(negedge clk); @(negedge clk);
    quiet("rst");
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1;
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h100;
    @(negedge clk);
    chk("ld_mem_req", mem_req, 1);
    chk("ld_mem_addr", mem_addr, 32'h100);
    chk("ld_mem_we", mem_we, 0);
    mem_ready = 1; mem_rdata = 64'h0123456789ABCDEF;
    @(negedge clk);
    chk("ld_d_ack", d_ack, 1);
    chk("ld_if_ack", if_ack, 0);
    chk("ld_rdata", rdata, 64'h0123456789ABCDEF);
    chk("ld_err", err, 0);
    chk("ld_mem_req_off", mem_req, 0);
    d_req = 0; mem_ready = 0;
    @(negedge clk);
    quiet("ld_idle");
    d_req = 1; d_we = 1; d_wdata = 64'hDEADBEEF; d_addr = 32'h200;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("st_mem_req", mem_req, 1);
      chk("st_mem_we", mem_we, 1);
      chk("st_mem_wdata", mem_wdata, 64'hDEADBEEF);
      chk("st_mem_addr", mem_addr, 32'h200);
      chk("st_d_ack", d_ack, 0);
      chk("st_if_ack", if_ack, 0);
      if (c == 2) begin d_wdata = 64'h1111; d_addr = 32'h999; end
      if (c == 4) begin mem_ready = 1; mem_rdata = 64'h7777; end
    end
    @(negedge clk);
    chk("st_d_ack", d_ack, 1);
    chk("st_if_ack", if_ack, 0);
    chk("st_rdata", rdata, 0);
    chk("st_err", err, 0);
    d_req = 0; d_we = 0; mem_ready = 0;
    @(negedge clk);
    quiet("st_idle");
    run_both(10);
    if_req = 1; if_addr = 32'h3000; mem_ready = 0; mem_rdata = 64'hFFFF;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("to_mem_req", mem_req, 1);
      chk("to_if_ack", if_ack, 0);
    end
    @(negedge clk);
    chk("to_if_ack", if_ack, 1);
    chk("to_d_ack", d_ack, 0);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 0);
    chk("to_mem_req_off", mem_req, 0);
    if_req = 0; mem_ready = 1;
    @(negedge clk);
    quiet("to_late_ready");
    mem_ready = 0;
    @(negedge clk);
    quiet("to_after");
    d_req = 1; d_we = 0; d_addr = 32'h400;
    @(negedge clk);
    chk("rst_busy1", mem_req, 1);
    @(negedge clk);
    chk("rst_busy2", mem_req, 1);
    #2 rst_n = 0;
    #1 chk("rst_mem_req_drop", mem_req, 0);
    chk("rst_no_ack", d_ack, 0);
    d_req = 0;
    @(negedge clk);
    quiet("rst_hold");
    rst_n = 1;
    @(negedge clk);
    quiet("rst_release");
    if_req = 1; if_addr = 32'h500;
    @(negedge clk);
    chk("post_mem_req", mem_req, 1);
    chk("post_mem_addr", mem_addr, 32'h500);
    chk("post_mem_we", mem_we, 0);
    mem_ready = 1; mem_rdata = 64'h55;
    @(negedge clk);
    chk("post_if_ack", if_ack, 1);
    chk("post_d_ack", d_ack, 0);
    chk("post_err", err, 0);
    chk("post_rdata", rdata, 64'h55);
    if_req = 0; mem_ready = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      quiet("hold");
    end
    run_both(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
